// File: rtl/puf_pkg.sv
// puf_pkg: shared definitions for the arbiter-PUF evaluation controller.
//   state_t    - controller states (IDLE, SETTLE, RACE, DONE)
//   *_DEFAULT  - default array width, evaluation count and phase lengths
//   acc_width  - width of a per-bit vote accumulator that counts up to neval
package puf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RACE,
    DONE
  } state_t;

  localparam int N_DEFAULT          = 128;
  localparam int NEVAL_DEFAULT      = 5;
  localparam int SETTLE_CYC_DEFAULT = 4;
  localparam int RACE_CYC_DEFAULT   = 8;

  // Enough bits to hold 0..neval, so an accumulator can never wrap.
  function automatic int acc_width(input int neval);
    return $clog2(neval + 1);
  endfunction

endpackage

// File: rtl/puf_bit_accum.sv
// puf_bit_accum: vote counter for one PUF response bit.
//   clk, rst  - clock and synchronous active-high reset
//   clear     - zero the count before a new challenge
//   en        - add sample into the count this cycle
//   sample    - response bit from the array
//   majority  - count (including this cycle's sample when en=1) exceeds NEVAL/2
//   unstable  - count (same view) is neither 0 nor NEVAL
module puf_bit_accum
  import puf_pkg::*;
#(
  parameter int NEVAL = NEVAL_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic sample,
  output logic majority,
  output logic unstable
);

  localparam int AW = acc_width(NEVAL);

  logic [AW-1:0] acc;
  logic [AW-1:0] acc_next;

  // The vote outputs look at the post-update count so the controller can
  // register the final result on the same edge that takes the last sample.
  always_comb begin
    acc_next = acc;
    if (en) begin
      acc_next = acc + AW'(sample);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_next;
    end
  end

  assign majority = (acc_next > AW'(NEVAL / 2));
  assign unstable = (acc_next != '0) && (acc_next != AW'(NEVAL));

endmodule

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: drives a challenge into the arbiter PUF array, launches the
// race NEVAL times (each launch preceded by a settle gap), and reports a
// per-bit majority response plus a mask of bits that disagreed.
//   clk, rst       - clock and synchronous active-high reset
//   start          - begin an evaluation (only honoured in IDLE)
//   abort          - cancel an evaluation in progress
//   challenge_in   - challenge captured when start is accepted
//   puf_response   - response bits from the array
//   puf_challenge  - latched challenge driven to the array
//   puf_signal     - race launch signal to the array
//   busy           - controller is not IDLE
//   done           - one-cycle pulse, response_out/unstable_mask just updated
//   response_out   - majority-voted response
//   unstable_mask  - bits whose samples were not unanimous
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int N          = N_DEFAULT,
  parameter int NEVAL      = NEVAL_DEFAULT,
  parameter int SETTLE_CYC = SETTLE_CYC_DEFAULT,
  parameter int RACE_CYC   = RACE_CYC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] challenge_in,
  input  logic [N-1:0] puf_response,
  output logic [N-1:0] puf_challenge,
  output logic         puf_signal,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] response_out,
  output logic [N-1:0] unstable_mask
);

  localparam int         EW          = acc_width(NEVAL);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] RACE_LAST   = 8'(RACE_CYC - 1);

  state_t        state;
  logic [7:0]    phase;
  logic [EW-1:0] eval_cnt;
  logic          acc_clear;
  logic          acc_en;
  logic [N-1:0]  maj;
  logic [N-1:0]  unst;

  // Accumulators clear when a new challenge is accepted and take one sample
  // on the final race cycle, unless that cycle is being aborted.
  assign acc_clear = (state == IDLE) && start;
  assign acc_en    = (state == RACE) && (phase == RACE_LAST) && !abort;

  for (genvar i = 0; i < N; i++) begin : g_bit
    puf_bit_accum #(
      .NEVAL(NEVAL)
    ) u_accum (
      .clk      (clk),
      .rst      (rst),
      .clear    (acc_clear),
      .en       (acc_en),
      .sample   (puf_response[i]),
      .majority (maj[i]),
      .unstable (unst[i])
    );
  end

  // Sequencer: settle gap, race pulse, repeat NEVAL times, then publish.
  // The result registers load on the last sample edge so they are valid in
  // the same cycle that done is high. Abort beats every other transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      phase         <= '0;
      eval_cnt      <= '0;
      puf_challenge <= '0;
      puf_signal    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      response_out  <= '0;
      unstable_mask <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state      <= IDLE;
        phase      <= '0;
        puf_signal <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              puf_challenge <= challenge_in;
              eval_cnt      <= '0;
              phase         <= '0;
              busy          <= 1'b1;
              state         <= SETTLE;
            end
          end
          SETTLE: begin
            if (phase == SETTLE_LAST) begin
              phase      <= '0;
              puf_signal <= 1'b1;
              state      <= RACE;
            end else begin
              phase <= phase + 8'd1;
            end
          end
          RACE: begin
            if (phase == RACE_LAST) begin
              phase      <= '0;
              puf_signal <= 1'b0;
              eval_cnt   <= eval_cnt + EW'(1);
              if (eval_cnt == EW'(NEVAL - 1)) begin
                done          <= 1'b1;
                response_out  <= maj;
                unstable_mask <= unst;
                state         <= DONE;
              end else begin
                state <= SETTLE;
              end
            end else begin
              phase <= phase + 8'd1;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb_puf_eval_ctrl: self-checking bench for puf_eval_ctrl at default sizes.
// The PUF array is modelled as response = challenge ^ A5 pattern ^ a per-
// evaluation flip mask; expected results come from a vote-counting model or
// from hand-derived table entries.
module tb_puf_eval_ctrl;

  localparam int N          = 128;
  localparam int NEVAL      = 5;
  localparam int SETTLE_CYC = 4;
  localparam int RACE_CYC   = 8;
  localparam int PERIOD     = SETTLE_CYC + RACE_CYC;
  localparam int DONE_AT    = NEVAL * PERIOD + 1;
  localparam logic [N-1:0] PAT = {16{8'hA5}};

  typedef logic [NEVAL-1:0][N-1:0] flips_t;

  typedef struct {
    string        name;
    logic [N-1:0] ch;
    flips_t       fl;
    logic [N-1:0] exp_resp;
    logic [N-1:0] exp_mask;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] challenge_in = '0;
  logic [N-1:0] puf_response;
  logic [N-1:0] puf_challenge;
  logic         puf_signal;
  logic         busy;
  logic         done;
  logic [N-1:0] response_out;
  logic [N-1:0] unstable_mask;

  int           errors = 0;
  int           checks = 0;
  flips_t       flips = '0;
  int           eval_idx = 0;
  logic         prev_sig = 1'b0;
  logic [N-1:0] last_resp = '0;
  logic [N-1:0] last_mask = '0;

  puf_eval_ctrl #(
    .N          (N),
    .NEVAL      (NEVAL),
    .SETTLE_CYC (SETTLE_CYC),
    .RACE_CYC   (RACE_CYC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .abort         (abort),
    .challenge_in  (challenge_in),
    .puf_response  (puf_response),
    .puf_challenge (puf_challenge),
    .puf_signal    (puf_signal),
    .busy          (busy),
    .done          (done),
    .response_out  (response_out),
    .unstable_mask (unstable_mask)
  );

  always #5 clk = ~clk;

  // Array model: the evaluation index advances on each falling edge of the
  // race signal and restarts whenever the controller takes a new challenge.
  always @(negedge clk) begin
    if (rst) begin
      eval_idx = 0;
    end else if (start && !busy) begin
      eval_idx = 0;
    end else if (prev_sig && !puf_signal) begin
      eval_idx = eval_idx + 1;
    end
    prev_sig = puf_signal;
  end

  always_comb begin
    puf_response = puf_challenge ^ PAT;
    if (eval_idx < NEVAL) begin
      puf_response = puf_challenge ^ PAT ^ flips[eval_idx];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Reference vote: count ones per bit across all evaluations.
  function automatic void model_eval(input logic [N-1:0] ch, input flips_t fl,
                                     output logic [N-1:0] resp, output logic [N-1:0] mask);
    logic [N-1:0] s;
    int ones;
    resp = '0;
    mask = '0;
    for (int i = 0; i < N; i++) begin
      ones = 0;
      for (int k = 0; k < NEVAL; k++) begin
        s = ch ^ PAT ^ fl[k];
        ones += int'(s[i]);
      end
      resp[i] = (2 * ones > NEVAL);
      mask[i] = (ones != 0) && (ones != NEVAL);
    end
  endfunction

  // One full evaluation started in the current cycle (cycle 0). Optional
  // start pulses at relative cycles pulse_a/pulse_b land while busy.
  task automatic apply_stimulus(input string tag, input logic [N-1:0] ch, input flips_t fl,
                                input logic [N-1:0] exp_resp, input logic [N-1:0] exp_mask,
                                input int pulse_a, input int pulse_b, input logic abort_too);
    int   done_cyc;
    int   done_cnt;
    int   sig_bad;
    int   chal_bad;
    int   t;
    logic exp_sig;
    logic busy1;
    logic busy_after;
    flips        = fl;
    challenge_in = ch;
    start        = 1'b1;
    abort        = abort_too;
    tick();
    start        = 1'b0;
    abort        = 1'b0;
    challenge_in = ~ch;
    busy1        = busy;
    busy_after   = 1'bx;
    done_cyc     = -1;
    done_cnt     = 0;
    sig_bad      = 0;
    chal_bad     = 0;
    t            = 1;
    while (t <= DONE_AT + 40) begin
      exp_sig = (t <= NEVAL * PERIOD) && (((t - 1) % PERIOD) >= SETTLE_CYC);
      if (puf_signal !== exp_sig) sig_bad++;
      if (puf_challenge !== ch) chal_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = t;
      end
      if (done_cyc >= 0 && t == done_cyc + 1) begin
        busy_after = busy;
        break;
      end
      start        = (t == pulse_a) || (t == pulse_b);
      challenge_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      t++;
    end
    start = 1'b0;
    check_bit({tag, " busy_cycle1"}, busy1, 1'b1);
    check_int({tag, " done_cycle"}, done_cyc, DONE_AT);
    check_int({tag, " done_pulses"}, done_cnt, 1);
    check_bit({tag, " busy_after_done"}, busy_after, 1'b0);
    check_int({tag, " race_waveform_errs"}, sig_bad, 0);
    check_int({tag, " challenge_changes"}, chal_bad, 0);
    check_output({tag, " response_out"}, response_out, exp_resp);
    check_output({tag, " unstable_mask"}, unstable_mask, exp_mask);
    last_resp = exp_resp;
    last_mask = exp_mask;
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, " puf_challenge"}, puf_challenge, '0);
    check_bit({tag, " puf_signal"}, puf_signal, 1'b0);
    check_bit({tag, " busy"}, busy, 1'b0);
    check_bit({tag, " done"}, done, 1'b0);
    check_output({tag, " response_out"}, response_out, '0);
    check_output({tag, " unstable_mask"}, unstable_mask, '0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t         vecs[5];
    flips_t       fl;
    flips_t       rfl;
    logic [N-1:0] rch;
    logic [N-1:0] mresp;
    logic [N-1:0] mmask;
    int           dcnt;

    fl = '0;
    vecs[0] = '{"stable", 128'h1, fl, 128'h1 ^ PAT, '0};
    fl = '0; fl[0] = 128'h80; fl[3] = 128'h80;
    vecs[1] = '{"noisy_bit7", 128'h1, fl, 128'h1 ^ PAT, 128'h80};
    fl = '0; fl[0] = 128'h1; fl[1] = 128'h1; fl[2] = 128'h1;
    vecs[2] = '{"flip3of5_bit0", 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, fl,
                128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D ^ PAT ^ 128'h1, 128'h1};
    fl = '0; for (int k = 0; k < NEVAL; k++) fl[k] = {8'hF0, 120'h0};
    vecs[3] = '{"flip_all_evals", '1, fl, ~PAT ^ {8'hF0, 120'h0}, '0};
    fl = '0; fl[4] = {1'b1, 127'h0};
    vecs[4] = '{"flip_last_msb", 128'h1234, fl, 128'h1234 ^ PAT, {1'b1, 127'h0}};

    // Reset state.
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Abort in IDLE does nothing.
    abort = 1'b1;
    tick();
    tick();
    abort = 1'b0;
    check_bit("idle_abort busy", busy, 1'b0);

    // Table-driven vectors; the second run also carries ignored start pulses
    // and the third is started in the cycle right after the previous done.
    for (int v = 0; v < 5; v++) begin
      apply_stimulus(vecs[v].name, vecs[v].ch, vecs[v].fl, vecs[v].exp_resp, vecs[v].exp_mask,
                     (v == 1) ? 10 : -1, (v == 1) ? 30 : -1, 1'b0);
    end

    // Abort at cycle 20: idle at 21, signal low, no done, results retained.
    flips        = '0;
    challenge_in = 128'h5555;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t < 20; t++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_bit("abort busy", busy, 1'b0);
    check_bit("abort puf_signal", puf_signal, 1'b0);
    dcnt = 0;
    for (int t = 0; t < 70; t++) begin
      if (done === 1'b1) dcnt++;
      tick();
    end
    check_int("abort done_pulses", dcnt, 0);
    check_output("abort response_out", response_out, last_resp);
    check_output("abort unstable_mask", unstable_mask, last_mask);

    // Reset asserted at cycle 25 of an evaluation.
    fl = '0; fl[1] = 128'hFF;
    flips        = fl;
    challenge_in = 128'h77;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 1; t < 25; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrun_reset");
    fl = '0;
    apply_stimulus("after_reset", 128'h1, fl, 128'h1 ^ PAT, '0, -1, -1, 1'b0);

    // Randomised runs against the vote model; the first also holds abort
    // alongside start, which start must win.
    for (int r = 0; r < 6; r++) begin
      rch = {$urandom(), $urandom(), $urandom(), $urandom()};
      for (int k = 0; k < NEVAL; k++) begin
        rfl[k] = {$urandom(), $urandom(), $urandom(), $urandom()} &
                 {$urandom(), $urandom(), $urandom(), $urandom()} &
                 {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      model_eval(rch, rfl, mresp, mmask);
      apply_stimulus($sformatf("random%0d", r), rch, rfl, mresp, mmask, -1, -1, r == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Sequencing controller for the N-bit arbiter PUF array. It latches a challenge, drives it onto the array, and launches the shared race signal NEVAL times with a settle gap before each launch. After each race it samples the array's response bits and produces a per-bit majority-voted response plus a mask of bits that did not agree across evaluations. It sits between the host/authentication logic and the PUF array, and is the only driver of the array's challenge and race-signal inputs.

## Interface
- N, 128, challenge/response width; matches the PUF array width.
- NEVAL, 5, evaluations per challenge; odd, 1..15.
- SETTLE_CYC, 4, cycles the race signal is held low with the challenge stable before each launch; 1..255.
- RACE_CYC, 8, cycles the race signal is held high before sampling; 1..255.
- clk  in  1  single clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to evaluate; accepted only in IDLE.
- abort  in  1  cancels an evaluation in progress.
- challenge_in  in  N  challenge; sampled on the cycle start is accepted.
- puf_response  in  N  response bits from the PUF array.
- puf_challenge  out  N  challenge driven to the PUF array.
- puf_signal  out  1  race launch signal driven to the PUF array.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse; marks response_out/unstable_mask as valid.
- response_out  out  N  majority-voted response.
- unstable_mask  out  N  bit i = 1 when the NEVAL samples of bit i were not unanimous.

## Operation
- States: IDLE, SETTLE, RACE, DONE.
- IDLE: when start=1, latch challenge_in into puf_challenge, clear all per-bit accumulators and the evaluation counter, and go to SETTLE. start while busy is ignored; no queueing.
- SETTLE: puf_signal=0 for SETTLE_CYC cycles, then go to RACE.
- RACE: puf_signal=1 for RACE_CYC cycles. On the last RACE cycle, add puf_response[i] into accumulator i and increment the evaluation counter.
  - If the counter then equals NEVAL, go to DONE; otherwise go back to SETTLE.
- DONE, one cycle:
  - done=1.
  - response_out[i] = (acc[i] > NEVAL/2).
  - unstable_mask[i] = (acc[i] != 0 && acc[i] != NEVAL).
  - Next state is IDLE.
- response_out and unstable_mask hold their values until the next DONE or reset.
- Accumulator width is clog2(NEVAL+1), which is 3 bits at the default. Accumulators must never wrap.
- puf_challenge is held constant from acceptance until the next accepted start. It does not change during SETTLE or RACE.
- abort=1 in any non-IDLE state:
  - Next cycle the state is IDLE and puf_signal=0.
  - No done pulse.
  - response_out and unstable_mask are unchanged.
  - abort in IDLE has no effect. abort and start together in IDLE: start wins.
- Reset, including mid-evaluation: state=IDLE and every output is 0 on the following cycle (puf_challenge, puf_signal, busy, done, response_out, unstable_mask). Accumulators and counters are cleared.

## Timing
- start is accepted at edge 0. busy=1 from cycle 1.
- Evaluation k (0-based) occupies SETTLE_CYC low cycles then RACE_CYC high cycles.
- done is asserted in cycle NEVAL*(SETTLE_CYC+RACE_CYC)+1. That is cycle 61 at the defaults.
- busy drops to 0 in the cycle after done. start is accepted again from that cycle.
- puf_response is sampled once per evaluation, on the final RACE cycle. RACE_CYC must cover the array's race and arbitration delay.
- puf_signal is registered and has no combinational path from any input.

## Structure
- Shared package puf_pkg holds:
  - the state enum (IDLE, SETTLE, RACE, DONE);
  - default values of N, NEVAL, SETTLE_CYC and RACE_CYC;
  - a function for accumulator width.
- Natural sub-module: puf_bit_accum. It holds one per-bit saturating-free counter with clear and enable, and produces the majority and unanimity outputs. Instantiate it N times in a generate loop.
- The top level holds the FSM, the phase cycle counter and the evaluation counter.

## Test plan
- Stable PUF model (response = challenge ^ 128'hA5A5…): start with challenge 128'h1 gives done at cycle 61, response_out = 128'h1 ^ pattern, unstable_mask = 0.
- Noisy bit: the model flips bit 7 on evaluations 0 and 3 only. Expect response_out[7] = stable value (3 of 5) and unstable_mask = 128'h80.
- puf_signal waveform: at the defaults, exactly 5 high pulses of 8 cycles, each preceded by 4 low cycles. puf_challenge stays constant throughout.
- start pulsed at cycles 10 and 30 during busy: ignored, single done at 61. A start at cycle 62 is accepted, with done at 123.
- abort at cycle 20: idle at 21, puf_signal=0, no done pulse, previous response_out retained.
- rst asserted at cycle 25 mid-race: all outputs 0 at cycle 26. A new start afterwards completes normally with cleared accumulators.
